// File: rtl/led_seg7_pkg.sv
// Shared definitions for the 7-segment scan controller.
//   SEG_0..SEG_F : active-high segment patterns, bit order {g,f,e,d,c,b,a}
//   SEG_OFF      : all segments dark
//   scan_state_t : scan sequencer states
//   digit_t      : one stored digit (decimal point + hex nibble)
package led_seg7_pkg;

  localparam logic [6:0] SEG_0   = 7'h3f;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5b;
  localparam logic [6:0] SEG_3   = 7'h4f;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6d;
  localparam logic [6:0] SEG_6   = 7'h7d;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7f;
  localparam logic [6:0] SEG_9   = 7'h6f;
  localparam logic [6:0] SEG_A   = 7'h77;
  localparam logic [6:0] SEG_B   = 7'h7c;
  localparam logic [6:0] SEG_C   = 7'h39;
  localparam logic [6:0] SEG_D   = 7'h5e;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_F   = 7'h71;
  localparam logic [6:0] SEG_OFF = 7'h00;

  typedef enum logic [1:0] {
    S_OFF,
    S_BLANK,
    S_ON
  } scan_state_t;

  typedef struct packed {
    logic       dp;
    logic [3:0] data;
  } digit_t;

endpackage

// File: rtl/led_seg7_scan_ctrl_hex_decode.sv
// Hex nibble to 7-segment pattern, purely combinational.
//   hex : value 0..F
//   seg : segments {g,f,e,d,c,b,a}, active high
module seg7_hex_decode
  import led_seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/led_seg7_scan_ctrl.sv
// Time-multiplexed scan controller driving DIGITS common-cathode digits
// from one shared segment bus. Each digit slot starts with a blanking
// window (all selects off) to avoid ghosting. Digit values are written
// into a shadow bank and copied to the display bank only at a frame
// boundary, so a multi-digit value never appears half-updated.
//   clk, rst_n     : clock, synchronous active-low reset
//   enable         : 1 = scanning, 0 = display dark
//   wr_valid/ready : shadow write handshake (ready low while a commit pends)
//   wr_addr/data/dp: digit index, hex value, decimal point
//   commit         : request shadow -> display copy at next frame boundary
//   frame_done     : one-cycle pulse when the copy is applied
//   sm_cs_n        : digit selects, active low
//   sm_db, sm_dp   : segments a..g and decimal point, active high
module led_seg7_scan_ctrl
  import led_seg7_pkg::*;
#(
  parameter int DIGITS    = 2,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [2:0]        wr_addr,
  input  logic [3:0]        wr_data,
  input  logic              wr_dp,
  input  logic              commit,
  output logic              frame_done,
  output logic [DIGITS-1:0] sm_cs_n,
  output logic [6:0]        sm_db,
  output logic              sm_dp
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  scan_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             pending_reg, pending_next;

  digit_t shadow_reg  [DIGITS];
  digit_t display_reg [DIGITS];

  logic [DIGITS-1:0] cs_n_reg, cs_n_next;
  logic [6:0]        db_reg, db_next;
  logic              dp_reg, dp_next;
  logic              frame_done_reg;

  logic   frame_boundary;
  logic   copy_now;
  logic   wr_accept;
  logic   addr_ok;
  logic   lit;
  digit_t cur_digit;
  logic [6:0] seg_dec;

  // ---------------------------------------------------------------
  // Scan sequencer
  // ---------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    if (!enable) begin
      state_next = S_OFF;
      cnt_next   = '0;
      idx_next   = '0;
    end else begin
      case (state_reg)
        S_OFF: begin
          state_next = S_BLANK;
          cnt_next   = '0;
          idx_next   = '0;
        end
        S_BLANK, S_ON: begin
          if (cnt_reg == CNT_LAST) begin
            cnt_next   = '0;
            state_next = S_BLANK;
            idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
            if (state_reg == S_BLANK && cnt_reg == BLANK_LAST)
              state_next = S_ON;
          end
        end
        default: begin
          state_next = S_OFF;
          cnt_next   = '0;
          idx_next   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Double-buffer control
  // ---------------------------------------------------------------
  // The frame ends on the last cycle of the last digit's slot.
  assign frame_boundary = (state_reg == S_ON) && (cnt_reg == CNT_LAST) &&
                          (idx_reg == IDX_LAST);
  // With the display dark there is no tearing to avoid, so copy at once.
  assign copy_now  = pending_reg && (frame_boundary || state_reg == S_OFF);
  assign wr_ready  = ~pending_reg;
  assign wr_accept = wr_valid & wr_ready;
  // Out-of-range addresses complete the handshake but store nothing.
  assign addr_ok   = ({29'd0, wr_addr} < 32'(DIGITS));

  always_comb begin
    pending_next = pending_reg;
    if (copy_now)
      pending_next = 1'b0;
    else if (commit && !pending_reg)
      pending_next = 1'b1;
  end

  // ---------------------------------------------------------------
  // Pin drive, registered one cycle after state/index
  // ---------------------------------------------------------------
  // Gating with enable directly darkens the pins on the very edge that
  // samples enable low, rather than one cycle later via the state.
  assign lit       = enable && (state_reg == S_ON);
  assign cur_digit = display_reg[idx_reg];

  seg7_hex_decode u_hex_decode (
    .hex (cur_digit.data),
    .seg (seg_dec)
  );

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_cs
      assign cs_n_next[gi] = ~(lit && (idx_reg == IDX_W'(gi)));
    end
  endgenerate

  assign db_next = lit ? seg_dec : SEG_OFF;
  assign dp_next = lit & cur_digit.dp;

  // ---------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= enable ? S_BLANK : S_OFF;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      pending_reg    <= 1'b0;
      cs_n_reg       <= '1;
      db_reg         <= SEG_OFF;
      dp_reg         <= 1'b0;
      frame_done_reg <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        shadow_reg[i]  <= '0;
        display_reg[i] <= '0;
      end
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      pending_reg    <= pending_next;
      cs_n_reg       <= cs_n_next;
      db_reg         <= db_next;
      dp_reg         <= dp_next;
      frame_done_reg <= copy_now;
      // Writes are only accepted while nothing is pending and the copy
      // only happens while pending, so the two never collide.
      if (wr_accept && addr_ok)
        shadow_reg[wr_addr[IDX_W-1:0]] <= '{dp: wr_dp, data: wr_data};
      if (copy_now) begin
        for (int i = 0; i < DIGITS; i++)
          display_reg[i] <= shadow_reg[i];
      end
    end
  end

  assign sm_cs_n    = cs_n_reg;
  assign sm_db      = db_reg;
  assign sm_dp      = dp_reg;
  assign frame_done = frame_done_reg;

endmodule
